// File: rtl/npu_mem_pkg.sv
// rtl/npu_mem_pkg.sv - shared types and constants for the NPU burst memory
// FSM state encodings, burst limits, stall LFSR seeds and small helpers.
package npu_mem_pkg;

  localparam int MAX_BURST = 16;
  localparam int BURST_W   = 5;

  localparam logic [15:0] LFSR_SEED_RD = 16'hACE1;
  localparam logic [15:0] LFSR_SEED_WR = 16'h1D2B;

  typedef enum logic {R_IDLE, R_BURST} rd_state_e;
  typedef enum logic {W_IDLE, W_BURST} wr_state_e;

  // A zero burstcount is served as a single beat.
  function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/npu_dp_ram.sv
// rtl/npu_dp_ram.sv - simple dual-port RAM, one write port, one registered read port
// A same-address read and write on one edge returns the previous contents.
module npu_dp_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/npu_burst_mem.sv
// rtl/npu_burst_mem.sv - burst memory with independent read and write slave ports
// Define NPU_BURST_MEM_STALL_EN to inject LFSR-driven waitrequest stalls.
module npu_burst_mem
  import npu_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_s_read,
  input  logic [31:0]           rd_s_address,
  input  logic [BURST_W-1:0]    rd_s_burstcount,
  output logic                  rd_s_waitrequest,
  output logic [DATA_WIDTH-1:0] rd_s_readdata,
  output logic                  rd_s_readdatavalid,
  input  logic                  wr_s_write,
  input  logic [31:0]           wr_s_address,
  input  logic [BURST_W-1:0]    wr_s_burstcount,
  input  logic [DATA_WIDTH-1:0] wr_s_writedata,
  output logic                  wr_s_waitrequest,
  output logic                  err_burst0
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int OFF = $clog2(DATA_WIDTH / 8);

  rd_state_e             rd_state_q;
  logic [AW-1:0]         rd_base_q;
  logic [BURST_W-1:0]    rd_len_q, rd_cnt_q;
  logic                  rd_pipe_q, rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  wr_state_e             wr_state_q;
  logic [AW-1:0]         wr_base_q;
  logic [BURST_W-1:0]    wr_len_q, wr_cnt_q;
  logic                  ready_q, err_q;

  logic                  rd_stall, wr_stall, rd_accept, wr_accept;
  logic [BURST_W-1:0]    rd_len_in, wr_len_in;
  logic                  ram_re, ram_we;
  logic [AW-1:0]         ram_raddr, ram_waddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr;

`ifdef NPU_BURST_MEM_STALL_EN
  logic [15:0] rd_lfsr_q, wr_lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_lfsr_q <= LFSR_SEED_RD;
      wr_lfsr_q <= LFSR_SEED_WR;
    end else begin
      rd_lfsr_q <= lfsr_next(rd_lfsr_q);
      wr_lfsr_q <= lfsr_next(wr_lfsr_q);
    end
  end

  assign rd_stall = (rd_state_q == R_IDLE) && (rd_lfsr_q[1:0] == 2'b00);
  assign wr_stall = (wr_lfsr_q[1:0] == 2'b00);
`else
  assign rd_stall = 1'b0;
  assign wr_stall = 1'b0;
`endif

  // Read stays stalled until its last beat has left the output register.
  assign rd_s_waitrequest   = !ready_q || (rd_state_q != R_IDLE) || rd_pipe_q || rd_valid_q || rd_stall;
  assign wr_s_waitrequest   = !ready_q || wr_stall;
  assign rd_s_readdata      = rd_data_q;
  assign rd_s_readdatavalid = rd_valid_q;
  assign err_burst0         = err_q;

  assign rd_accept = rd_s_read && !rd_s_waitrequest;
  assign wr_accept = wr_s_write && !wr_s_waitrequest;
  assign rd_len_in = burst_len(rd_s_burstcount);
  assign wr_len_in = burst_len(wr_s_burstcount);

  // Beat 0 is looked up straight from the request so read-before-write holds at command level.
  assign ram_re    = rd_accept || (rd_state_q == R_BURST);
  assign ram_raddr = (rd_state_q == R_IDLE) ? rd_s_address[OFF +: AW] : rd_base_q + AW'(rd_cnt_q);
  assign ram_we    = wr_accept;
  assign ram_waddr = (wr_state_q == W_IDLE) ? wr_s_address[OFF +: AW] : wr_base_q + AW'(wr_cnt_q);

  assign unused_addr = ^{rd_s_address[31:OFF+AW], rd_s_address[OFF-1:0],
                         wr_s_address[31:OFF+AW], wr_s_address[OFF-1:0]};

  npu_dp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(wr_s_writedata),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_base_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_pipe_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pipe_q  <= ram_re;
      rd_valid_q <= rd_pipe_q;
      rd_data_q  <= rd_pipe_q ? ram_rdata : '0;
      case (rd_state_q)
        R_IDLE: if (rd_accept) begin
          rd_base_q <= rd_s_address[OFF +: AW];
          rd_len_q  <= rd_len_in;
          if (rd_len_in != BURST_W'(1)) begin
            rd_cnt_q   <= BURST_W'(1);
            rd_state_q <= R_BURST;
          end
        end
        R_BURST: begin
          if (rd_cnt_q == rd_len_q - BURST_W'(1)) begin
            rd_cnt_q   <= '0;
            rd_state_q <= R_IDLE;
          end else begin
            rd_cnt_q <= rd_cnt_q + BURST_W'(1);
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      wr_base_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (wr_accept) begin
          wr_base_q <= wr_s_address[OFF +: AW];
          wr_len_q  <= wr_len_in;
          if (wr_len_in != BURST_W'(1)) begin
            wr_cnt_q   <= BURST_W'(1);
            wr_state_q <= W_BURST;
          end
        end
        W_BURST: if (wr_accept) begin
          if (wr_cnt_q == wr_len_q - BURST_W'(1)) begin
            wr_cnt_q   <= '0;
            wr_state_q <= W_IDLE;
          end else begin
            wr_cnt_q <= wr_cnt_q + BURST_W'(1);
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if ((rd_accept && rd_s_burstcount == '0) ||
          (wr_accept && wr_state_q == W_IDLE && wr_s_burstcount == '0))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_npu_burst_mem.sv
// tb/tb_npu_burst_mem.sv - self-checking bench for npu_burst_mem
// Directed and randomized bursts checked against a word-array memory model.
module tb_npu_burst_mem;

  localparam int DW    = 64;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_s_read;
  logic [31:0]   rd_s_address;
  logic [4:0]    rd_s_burstcount;
  logic          rd_s_waitrequest;
  logic [DW-1:0] rd_s_readdata;
  logic          rd_s_readdatavalid;
  logic          wr_s_write;
  logic [31:0]   wr_s_address;
  logic [4:0]    wr_s_burstcount;
  logic [DW-1:0] wr_s_writedata;
  logic          wr_s_waitrequest;
  logic          err_burst0;

  always #5 clk = ~clk;

  npu_burst_mem #(.DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rd_s_read         (rd_s_read),
    .rd_s_address      (rd_s_address),
    .rd_s_burstcount   (rd_s_burstcount),
    .rd_s_waitrequest  (rd_s_waitrequest),
    .rd_s_readdata     (rd_s_readdata),
    .rd_s_readdatavalid(rd_s_readdatavalid),
    .wr_s_write        (wr_s_write),
    .wr_s_address      (wr_s_address),
    .wr_s_burstcount   (wr_s_burstcount),
    .wr_s_writedata    (wr_s_writedata),
    .wr_s_waitrequest  (wr_s_waitrequest),
    .err_burst0        (err_burst0)
  );

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf  [16];
  int passed = 0;
  int total  = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 8) % DEPTH);
  endfunction

  function automatic int blen(input logic [4:0] bc);
    return (bc == 0) ? 1 : int'(bc);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [4:0] bc, input bit gaps);
    int n, base, t, stalls;
    n = blen(bc); base = widx(a); stalls = 0;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wr_s_write = 1'b0; wr_s_address = $urandom; wr_s_burstcount = 5'($urandom);
        wr_s_writedata = {$urandom, $urandom};
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wr_s_write      = 1'b1;
      wr_s_address    = (k == 0) ? a : $urandom;
      wr_s_burstcount = (k == 0) ? bc : 5'($urandom);
      wr_s_writedata  = wbuf[k];
      t = 0;
      while (wr_s_waitrequest && t < 50) begin @(negedge clk); t++; end
      stalls += t;
      @(negedge clk);
      model[(base + k) % DEPTH] = wbuf[k];
    end
    wr_s_write = 1'b0;
    total++;
    if (stalls != 0) $display("FAIL wr_wait_zero: stall cycles %0d, required 0", stalls);
    else passed++;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [4:0] bc);
    int n, base, t;
    logic [DW-1:0] exp;
    n = blen(bc); base = widx(a); t = 0;
    @(negedge clk);
    rd_s_read = 1'b1; rd_s_address = a; rd_s_burstcount = bc;
    while (rd_s_waitrequest && t < 50) begin @(negedge clk); t++; end
    total++;
    if (t >= 50) $display("FAIL rd_accept_timeout: waited %0d cycles, required < 50", t);
    else passed++;
    @(negedge clk);
    rd_s_read = 1'b0; rd_s_address = $urandom; rd_s_burstcount = 5'($urandom);
    total++;
    if (rd_s_readdatavalid !== 1'b0) $display("FAIL rd_latency_early: valid %b one cycle after accept, required 0", rd_s_readdatavalid);
    else passed++;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp = model[(base + k) % DEPTH];
      total++;
      if ({rd_s_readdatavalid, rd_s_readdata} !== {1'b1, exp})
        $display("FAIL rd_beat%0d: valid %b data %h, required valid 1 data %h", k, rd_s_readdatavalid, rd_s_readdata, exp);
      else passed++;
    end
    total++;
    if (rd_s_waitrequest !== 1'b1) $display("FAIL rd_wait_last_beat: waitrequest %b, required 1", rd_s_waitrequest);
    else passed++;
    @(negedge clk);
    total++;
    if ({rd_s_readdatavalid, rd_s_waitrequest} !== 2'b00)
      $display("FAIL rd_after_burst: valid %b waitrequest %b, required 0 0", rd_s_readdatavalid, rd_s_waitrequest);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rd_s_waitrequest, wr_s_waitrequest, rd_s_readdatavalid, rd_s_readdata, err_burst0} !== {3'b110, {DW{1'b0}}, 1'b0})
      $display("FAIL reset_outputs: rdw %b wrw %b valid %b data %h err %b, required 1 1 0 0 0",
               rd_s_waitrequest, wr_s_waitrequest, rd_s_readdatavalid, rd_s_readdata, err_burst0);
    else passed++;
    rst_n = 1'b1;
    total++;
    if ({rd_s_waitrequest, wr_s_waitrequest} !== 2'b11)
      $display("FAIL reset_release_early: waits %b%b before first edge, required 11", rd_s_waitrequest, wr_s_waitrequest);
    else passed++;
    @(negedge clk);
    total++;
    if ({rd_s_waitrequest, wr_s_waitrequest} !== 2'b00)
      $display("FAIL reset_release: waits %b%b after first edge, required 00", rd_s_waitrequest, wr_s_waitrequest);
    else passed++;
  endtask

  task automatic test_write_burst;
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    do_write(32'h100, 5'd4, 1'b0);
  endtask

  task automatic test_read_burst;
    do_read(32'h100, 5'd4);
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 16; k++) wbuf[k] = {$urandom, $urandom};
    do_write((DEPTH - 2) * 8, 5'd16, 1'b1);
    do_read(32'h0, 5'd14);
    do_read((DEPTH - 2) * 8, 5'd16);
  endtask

  task automatic test_rbw;
    int t;
    wbuf[0] = 64'hAA;
    do_write(32'd40, 5'd1, 1'b0);
    @(negedge clk);
    rd_s_read = 1'b1; rd_s_address = 32'd40; rd_s_burstcount = 5'd1;
    wr_s_write = 1'b1; wr_s_address = 32'd40; wr_s_burstcount = 5'd1; wr_s_writedata = 64'hBB;
    t = 0;
    while ((rd_s_waitrequest || wr_s_waitrequest) && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    rd_s_read = 1'b0; wr_s_write = 1'b0;
    model[5] = 64'hBB;
    @(negedge clk);
    total++;
    if ({rd_s_readdatavalid, rd_s_readdata} !== {1'b1, 64'hAA})
      $display("FAIL rbw_old_data: valid %b data %h, required valid 1 data aa", rd_s_readdatavalid, rd_s_readdata);
    else passed++;
    do_read(32'd40, 5'd1);
  endtask

  task automatic test_burst0;
    total++;
    if (err_burst0 !== 1'b0) $display("FAIL err_before_burst0: err %b, required 0", err_burst0);
    else passed++;
    do_read(32'h100, 5'd0);
    total++;
    if (err_burst0 !== 1'b1) $display("FAIL err_after_rd_burst0: err %b, required 1", err_burst0);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (err_burst0 !== 1'b1) $display("FAIL err_sticky: err %b, required 1", err_burst0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int t, stray;
    @(negedge clk);
    rd_s_read = 1'b1; rd_s_address = 32'h0; rd_s_burstcount = 5'd8;
    t = 0;
    while (rd_s_waitrequest && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    rd_s_read = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({rd_s_readdatavalid, rd_s_readdata} !== {1'b1, model[2]})
      $display("FAIL mid_beat3: valid %b data %h, required valid 1 data %h", rd_s_readdatavalid, rd_s_readdata, model[2]);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rd_s_readdatavalid, rd_s_readdata, rd_s_waitrequest, wr_s_waitrequest, err_burst0} !== {1'b0, {DW{1'b0}}, 3'b110})
      $display("FAIL mid_reset_outputs: valid %b data %h rdw %b wrw %b err %b, required 0 0 1 1 0",
               rd_s_readdatavalid, rd_s_readdata, rd_s_waitrequest, wr_s_waitrequest, err_burst0);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_s_readdatavalid !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) $display("FAIL mid_no_stray_valid: %0d valid cycles after reset, required 0", stray);
    else passed++;
    do_read(32'h0, 5'd8);
    wbuf[0] = {$urandom, $urandom};
    do_write(32'h200, 5'd0, 1'b0);
    total++;
    if (err_burst0 !== 1'b1) $display("FAIL err_after_wr_burst0: err %b, required 1", err_burst0);
    else passed++;
    do_read(32'h200, 5'd1);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [4:0]  bc;
    for (int i = 0; i < 8; i++) begin
      bc = 5'($urandom_range(1, 16));
      a  = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, DEPTH - 1) * 8) | 32'($urandom_range(0, 7));
      for (int k = 0; k < 16; k++) wbuf[k] = {$urandom, $urandom};
      do_write(a, bc, 1'b1);
      do_read(a, bc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_s_read = 1'b0; rd_s_address = '0; rd_s_burstcount = '0;
    wr_s_write = 1'b0; wr_s_address = '0; wr_s_burstcount = '0; wr_s_writedata = '0;
    test_reset;
    test_write_burst;
    test_read_burst;
    test_wrap;
    test_rbw;
    test_burst0;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
